// File: rtl/l2_tag_array_param_if.sv
// Request/update/result bundle for the parametrised L2 tag stage.
// The arbiter side drives lookups and metadata writes; the tag stage returns results.
interface l2_tag_array_param_if #(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 256,
    parameter int TAG_WIDTH = 18
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic                          init_done;
    logic                          lookup_valid;
    logic [SET_W-1:0]              lookup_set;
    logic [TAG_WIDTH-1:0]          lookup_tag;
    logic                          tag_valid;
    logic                          tag_hit;
    logic [WAY_W-1:0]              tag_hit_way;
    logic [WAY_W-1:0]              tag_victim_way;
    logic [NUM_WAYS*TAG_WIDTH-1:0] tag_way_tags;
    logic [NUM_WAYS-1:0]           tag_way_valid;
    logic [NUM_WAYS-1:0]           tag_way_dirty;
    logic                          update_tag_en;
    logic [SET_W-1:0]              update_tag_set;
    logic [WAY_W-1:0]              update_tag_way;
    logic [TAG_WIDTH-1:0]          update_tag_tag;
    logic                          update_tag_valid;
    logic [NUM_WAYS-1:0]           update_dirty_mask;
    logic [SET_W-1:0]              update_dirty_set;
    logic                          update_dirty_value;
    logic                          touch_en;
    logic [SET_W-1:0]              touch_set;
    logic [WAY_W-1:0]              touch_way;

    modport master (
        output lookup_valid, lookup_set, lookup_tag,
        output update_tag_en, update_tag_set, update_tag_way, update_tag_tag, update_tag_valid,
        output update_dirty_mask, update_dirty_set, update_dirty_value,
        output touch_en, touch_set, touch_way,
        input  init_done, tag_valid, tag_hit, tag_hit_way, tag_victim_way,
        input  tag_way_tags, tag_way_valid, tag_way_dirty
    );

    modport slave (
        input  lookup_valid, lookup_set, lookup_tag,
        input  update_tag_en, update_tag_set, update_tag_way, update_tag_tag, update_tag_valid,
        input  update_dirty_mask, update_dirty_set, update_dirty_value,
        input  touch_en, touch_set, touch_way,
        output init_done, tag_valid, tag_hit, tag_hit_way, tag_victim_way,
        output tag_way_tags, tag_way_valid, tag_way_dirty
    );
endinterface

// File: rtl/l2_tag_array_param.sv
// Parametrised L2 tag/metadata stage: per-way valid/tag/dirty plus tree PLRU per set,
// one-cycle lookup with write-first bypass and a post-reset metadata clearing sweep.
module l2_tag_array_param #(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 256,
    parameter int TAG_WIDTH = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    l2_tag_array_param_if.slave    bus
);
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LEVELS = $clog2(NUM_WAYS);
    localparam int PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    state_t                 state_r;
    logic [SET_W-1:0]       init_cnt_r;
    logic                   init_done_r;

    logic [TAG_WIDTH-1:0]   tag_r   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]    valid_r [NUM_SETS];
    logic [NUM_WAYS-1:0]    dirty_r [NUM_SETS];
    logic [PLRU_W-1:0]      plru_r  [NUM_SETS];

    logic                   accept_s;
    logic                   ready_s;
    logic                   upd_same_s;
    logic                   dirty_same_s;
    logic                   touch_same_s;
    logic [TAG_WIDTH-1:0]   byp_tag_s [NUM_WAYS];
    logic [NUM_WAYS-1:0]    byp_valid_s;
    logic [NUM_WAYS-1:0]    byp_dirty_s;
    logic [PLRU_W-1:0]      byp_plru_s;
    logic [NUM_WAYS-1:0]    match_s;
    logic                   hit_s;
    logic [WAY_W-1:0]       hit_way_s;
    logic [WAY_W-1:0]       victim_s;

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                      input logic [WAY_W-1:0] way);
        logic [PLRU_W-1:0] res;
        int                node;
        logic              dir;
        res  = bits;
        node = 0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            dir       = way[LEVELS-1-lvl];
            res[node] = ~dir;
            node      = 2 * node + 1 + {31'd0, dir};
        end
        return res;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [WAY_W-1:0] way;
        int               node;
        logic             dir;
        way  = '0;
        node = 0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            dir                 = bits[node];
            way[LEVELS-1-lvl]   = dir;
            node                = 2 * node + 1 + {31'd0, dir};
        end
        return way;
    endfunction

    assign ready_s      = (state_r == ST_READY);
    assign accept_s     = bus.lookup_valid && init_done_r;
    assign upd_same_s   = bus.update_tag_en && (bus.update_tag_set == bus.lookup_set);
    assign dirty_same_s = (bus.update_dirty_set == bus.lookup_set);
    assign touch_same_s = bus.touch_en && (bus.touch_set == bus.lookup_set);
    assign bus.init_done = init_done_r;

    // Init sweep sequencer: walks every set once after reset, then stays ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + SET_W'(1);
                    if (init_cnt_r == SET_W'(NUM_SETS - 1)) begin
                        state_r     <= ST_READY;
                        init_done_r <= 1'b1;
                    end
                end
                ST_READY: state_r <= ST_READY;
                default:  state_r <= ST_INIT;
            endcase
        end
    end

    // Metadata arrays: cleared set-by-set during init, independent write ports once ready.
    always_ff @(posedge clk) begin
        if (!ready_s) begin
            valid_r[init_cnt_r] <= '0;
            dirty_r[init_cnt_r] <= '0;
            plru_r[init_cnt_r]  <= '0;
        end else begin
            if (bus.update_tag_en) begin
                tag_r[bus.update_tag_set][bus.update_tag_way]   <= bus.update_tag_tag;
                valid_r[bus.update_tag_set][bus.update_tag_way] <= bus.update_tag_valid;
            end
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (bus.update_dirty_mask[i]) begin
                    dirty_r[bus.update_dirty_set][i] <= bus.update_dirty_value;
                end
            end
            if (bus.touch_en) begin
                plru_r[bus.touch_set] <= plru_touch(plru_r[bus.touch_set], bus.touch_way);
            end
        end
    end

    // Lookup datapath: read the set, fold in same-cycle writes, then derive hit and victim.
    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            byp_tag_s[i]   = (upd_same_s && (bus.update_tag_way == WAY_W'(i)))
                             ? bus.update_tag_tag : tag_r[bus.lookup_set][i];
            byp_valid_s[i] = (upd_same_s && (bus.update_tag_way == WAY_W'(i)))
                             ? bus.update_tag_valid : valid_r[bus.lookup_set][i];
            byp_dirty_s[i] = (dirty_same_s && bus.update_dirty_mask[i])
                             ? bus.update_dirty_value : dirty_r[bus.lookup_set][i];
            match_s[i]     = byp_valid_s[i] && (byp_tag_s[i] == bus.lookup_tag);
        end
        byp_plru_s = touch_same_s ? plru_touch(plru_r[bus.lookup_set], bus.touch_way)
                                  : plru_r[bus.lookup_set];
        hit_s     = |match_s;
        hit_way_s = '0;
        victim_s  = plru_victim(byp_plru_s);
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            hit_way_s = match_s[i]      ? WAY_W'(i) : hit_way_s;
            victim_s  = !byp_valid_s[i] ? WAY_W'(i) : victim_s;
        end
    end

    // Result registers: load on an accepted lookup, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.tag_valid      <= 1'b0;
            bus.tag_hit        <= 1'b0;
            bus.tag_hit_way    <= '0;
            bus.tag_victim_way <= '0;
            bus.tag_way_tags   <= '0;
            bus.tag_way_valid  <= '0;
            bus.tag_way_dirty  <= '0;
        end else begin
            bus.tag_valid <= accept_s;
            if (accept_s) begin
                bus.tag_hit        <= hit_s;
                bus.tag_hit_way    <= hit_way_s;
                bus.tag_victim_way <= victim_s;
                bus.tag_way_valid  <= byp_valid_s;
                bus.tag_way_dirty  <= byp_dirty_s;
                for (int i = 0; i < NUM_WAYS; i++) begin
                    bus.tag_way_tags[i*TAG_WIDTH +: TAG_WIDTH] <= byp_tag_s[i];
                end
            end
        end
    end

    l2_tag_array_param_chk #(.NUM_WAYS(NUM_WAYS)) u_chk (
        .clk          (clk),
        .reset        (reset),
        .init_done    (init_done_r),
        .lookup_valid (bus.lookup_valid),
        .match        (match_s)
    );
endmodule

// Protocol checker: no lookups before init completes, at most one matching way.
module l2_tag_array_param_chk #(
    parameter int NUM_WAYS = 4
) (
    input logic                clk,
    input logic                reset,
    input logic                init_done,
    input logic                lookup_valid,
    input logic [NUM_WAYS-1:0] match
);
    a_no_lookup_in_init: assert property (@(posedge clk) disable iff (reset)
        lookup_valid |-> init_done)
        else $error("lookup_valid asserted before init_done");

    a_single_match: assert property (@(posedge clk) disable iff (reset)
        (lookup_valid && init_done) |-> $onehot0(match))
        else $error("multiple ways match the lookup tag");
endmodule

// File: tb/tb_l2_tag_array_param.sv
// Directed bench for l2_tag_array_param: 4-way/8-set main instance plus 1/2/8-way, 2-set instances.
module tb_l2_tag_array_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    l2_tag_array_param_if #(.NUM_WAYS(4), .NUM_SETS(8), .TAG_WIDTH(18)) ia ();
    l2_tag_array_param_if #(.NUM_WAYS(1), .NUM_SETS(2), .TAG_WIDTH(8))  ib ();
    l2_tag_array_param_if #(.NUM_WAYS(2), .NUM_SETS(2), .TAG_WIDTH(8))  ic ();
    l2_tag_array_param_if #(.NUM_WAYS(8), .NUM_SETS(2), .TAG_WIDTH(8))  id ();

    l2_tag_array_param #(.NUM_WAYS(4), .NUM_SETS(8), .TAG_WIDTH(18)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    l2_tag_array_param #(.NUM_WAYS(1), .NUM_SETS(2), .TAG_WIDTH(8))  dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
    l2_tag_array_param #(.NUM_WAYS(2), .NUM_SETS(2), .TAG_WIDTH(8))  dut_c (.clk(clk), .reset(reset), .bus(ic.slave));
    l2_tag_array_param #(.NUM_WAYS(8), .NUM_SETS(2), .TAG_WIDTH(8))  dut_d (.clk(clk), .reset(reset), .bus(id.slave));

    task automatic check_value(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_clear();
        ia.lookup_valid = 1'b0; ia.update_tag_en = 1'b0; ia.update_dirty_mask = '0;
        ia.touch_en = 1'b0;     ia.update_dirty_value = 1'b0;
    endtask

    task automatic a_update(input int set, input int way, input int tag);
        ia.update_tag_en = 1'b1; ia.update_tag_set = 3'(set); ia.update_tag_way = 2'(way);
        ia.update_tag_tag = 18'(tag); ia.update_tag_valid = 1'b1;
    endtask

    task automatic a_lookup(input int set, input int tag);
        ia.lookup_valid = 1'b1; ia.lookup_set = 3'(set); ia.lookup_tag = 18'(tag);
    endtask

    task automatic a_touch(input int set, input int way);
        ia.touch_en = 1'b1; ia.touch_set = 3'(set); ia.touch_way = 2'(way);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ia.lookup_set = '0; ia.lookup_tag = '0; ia.update_tag_set = '0; ia.update_tag_way = '0;
        ia.update_tag_tag = '0; ia.update_tag_valid = 1'b0; ia.update_dirty_set = '0;
        ia.touch_set = '0; ia.touch_way = '0;
        a_clear();
        ib.lookup_valid = 1'b0; ib.lookup_set = '0; ib.lookup_tag = '0; ib.update_tag_en = 1'b0;
        ib.update_tag_set = '0; ib.update_tag_way = '0; ib.update_tag_tag = '0; ib.update_tag_valid = 1'b0;
        ib.update_dirty_mask = '0; ib.update_dirty_set = '0; ib.update_dirty_value = 1'b0;
        ib.touch_en = 1'b0; ib.touch_set = '0; ib.touch_way = '0;
        ic.lookup_valid = 1'b0; ic.lookup_set = '0; ic.lookup_tag = '0; ic.update_tag_en = 1'b0;
        ic.update_tag_set = '0; ic.update_tag_way = '0; ic.update_tag_tag = '0; ic.update_tag_valid = 1'b0;
        ic.update_dirty_mask = '0; ic.update_dirty_set = '0; ic.update_dirty_value = 1'b0;
        ic.touch_en = 1'b0; ic.touch_set = '0; ic.touch_way = '0;
        id.lookup_valid = 1'b0; id.lookup_set = '0; id.lookup_tag = '0; id.update_tag_en = 1'b0;
        id.update_tag_set = '0; id.update_tag_way = '0; id.update_tag_tag = '0; id.update_tag_valid = 1'b0;
        id.update_dirty_mask = '0; id.update_dirty_set = '0; id.update_dirty_value = 1'b0;
        id.touch_en = 1'b0; id.touch_set = '0; id.touch_way = '0;

        // Reset state
        tick(); tick(); tick();
        check_value("rst_init_done", 64'(ia.init_done), 64'd0);
        check_value("rst_tag_valid", 64'(ia.tag_valid), 64'd0);
        check_value("rst_tag_hit",   64'(ia.tag_hit), 64'd0);
        check_value("rst_victim",    64'(ia.tag_victim_way), 64'd0);
        check_value("rst_way_valid", 64'(ia.tag_way_valid), 64'd0);

        // Init sweep: 8 cycles with init_done low, high from the 8th edge
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_value($sformatf("init_done_edge%0d", k), 64'(ia.init_done), (k == 8) ? 64'd1 : 64'd0);
        end

        // Every set reads empty after the sweep
        for (int s = 0; s < 8; s++) begin
            a_lookup(s, 0);
            tick();
            check_value($sformatf("sweep_valid_s%0d", s), 64'(ia.tag_valid), 64'd1);
            check_value($sformatf("sweep_hit_s%0d", s), 64'(ia.tag_hit), 64'd0);
            check_value($sformatf("sweep_wv_s%0d", s), 64'(ia.tag_way_valid), 64'd0);
            check_value($sformatf("sweep_vict_s%0d", s), 64'(ia.tag_victim_way), 64'd0);
        end
        a_clear();

        // Fill and hit
        a_update(5, 2, 18'h2A); tick(); a_clear();
        a_lookup(5, 18'h2A); tick();
        check_value("fill_hit", 64'(ia.tag_hit), 64'd1);
        check_value("fill_hit_way", 64'(ia.tag_hit_way), 64'd2);
        a_lookup(5, 18'h2B); tick();
        check_value("miss_hit", 64'(ia.tag_hit), 64'd0);
        check_value("miss_victim", 64'(ia.tag_victim_way), 64'd0);
        check_value("miss_way_valid", 64'(ia.tag_way_valid), 64'b0100);
        a_clear();

        // Same-cycle bypass of tag, valid and dirty writes
        a_update(3, 1, 18'h11);
        ia.update_dirty_mask = 4'b0010; ia.update_dirty_set = 3'd3; ia.update_dirty_value = 1'b1;
        a_lookup(3, 18'h11); tick();
        check_value("byp_hit", 64'(ia.tag_hit), 64'd1);
        check_value("byp_hit_way", 64'(ia.tag_hit_way), 64'd1);
        check_value("byp_dirty", 64'(ia.tag_way_dirty), 64'b0010);
        check_value("byp_tag1", 64'(ia.tag_way_tags[1*18 +: 18]), 64'h11);
        a_clear();

        // Update to another set is invisible; visible the following cycle
        a_update(4, 0, 18'h55); a_lookup(6, 18'h55); tick();
        check_value("other_set_hit", 64'(ia.tag_hit), 64'd0);
        a_clear();
        a_lookup(4, 18'h55); tick();
        check_value("next_cycle_hit", 64'(ia.tag_hit), 64'd1);
        check_value("next_cycle_way", 64'(ia.tag_hit_way), 64'd0);
        a_clear(); tick();
        check_value("idle_tag_valid", 64'(ia.tag_valid), 64'd0);
        check_value("idle_hold_hit", 64'(ia.tag_hit), 64'd1);

        // Independent simultaneous writes to different sets
        a_update(1, 3, 18'h33);
        ia.update_dirty_mask = 4'b1000; ia.update_dirty_set = 3'd2; ia.update_dirty_value = 1'b1;
        tick(); a_clear();
        a_lookup(1, 18'h33); tick();
        check_value("simul_hit_way", 64'(ia.tag_hit_way), 64'd3);
        check_value("simul_dirty1", 64'(ia.tag_way_dirty), 64'd0);
        a_lookup(2, 18'h33); tick();
        check_value("simul_dirty2", 64'(ia.tag_way_dirty), 64'b1000);
        check_value("simul_valid2", 64'(ia.tag_way_valid), 64'd0);
        a_clear();

        // PLRU in a full set 7
        for (int w = 0; w < 4; w++) begin
            a_update(7, w, 18'h70 + w); tick();
        end
        a_clear();
        for (int w = 0; w < 4; w++) begin
            a_touch(7, w); tick();
        end
        a_clear();
        a_lookup(7, 18'h3FF); tick();
        check_value("plru_0123", 64'(ia.tag_victim_way), 64'd0);
        a_touch(7, 0); a_lookup(7, 18'h3FF); tick();
        check_value("plru_touch0_byp", 64'(ia.tag_victim_way), 64'd2);
        a_clear();
        a_touch(7, 2); tick(); a_clear();
        a_lookup(7, 18'h72); tick();
        check_value("plru_touch2", 64'(ia.tag_victim_way), 64'd1);
        check_value("plru_hit_way", 64'(ia.tag_hit_way), 64'd2);
        a_clear();

        // Reset during the 4th sweep cycle restarts the sweep
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_value($sformatf("reinit_edge%0d", k), 64'(ia.init_done), (k == 8) ? 64'd1 : 64'd0);
        end
        a_lookup(3, 18'h11); tick();
        check_value("reinit_s3_valid", 64'(ia.tag_way_valid), 64'd0);
        check_value("reinit_s3_dirty", 64'(ia.tag_way_dirty), 64'd0);
        check_value("reinit_s3_hit", 64'(ia.tag_hit), 64'd0);
        a_lookup(7, 18'h70); tick();
        check_value("reinit_s7_valid", 64'(ia.tag_way_valid), 64'd0);
        a_clear();

        // NUM_WAYS = 1
        check_value("w1_init_done", 64'(ib.init_done), 64'd1);
        ib.lookup_valid = 1'b1; ib.lookup_set = 1'b1; ib.lookup_tag = 8'h05; tick();
        check_value("w1_miss", 64'(ib.tag_hit), 64'd0);
        check_value("w1_victim_empty", 64'(ib.tag_victim_way), 64'd0);
        ib.lookup_valid = 1'b0;
        ib.update_tag_en = 1'b1; ib.update_tag_set = 1'b1; ib.update_tag_tag = 8'h05; ib.update_tag_valid = 1'b1;
        tick(); ib.update_tag_en = 1'b0;
        ib.touch_en = 1'b1; ib.touch_set = 1'b1; ib.lookup_valid = 1'b1; tick();
        check_value("w1_hit", 64'(ib.tag_hit), 64'd1);
        check_value("w1_victim_full", 64'(ib.tag_victim_way), 64'd0);
        check_value("w1_way_valid", 64'(ib.tag_way_valid), 64'd1);
        check_value("w1_nox", 64'($isunknown({ib.tag_hit, ib.tag_hit_way, ib.tag_victim_way, ib.tag_way_tags})), 64'd0);
        ib.lookup_valid = 1'b0; ib.touch_en = 1'b0;

        // NUM_WAYS = 2
        ic.update_tag_en = 1'b1; ic.update_tag_valid = 1'b1; ic.update_tag_set = 1'b0;
        ic.update_tag_way = 1'b0; ic.update_tag_tag = 8'h01; tick();
        ic.update_tag_way = 1'b1; ic.update_tag_tag = 8'h02; tick();
        ic.update_tag_en = 1'b0;
        ic.touch_en = 1'b1; ic.touch_set = 1'b0; ic.touch_way = 1'b0; tick(); ic.touch_en = 1'b0;
        ic.lookup_valid = 1'b1; ic.lookup_set = 1'b0; ic.lookup_tag = 8'h02; tick();
        check_value("w2_hit_way", 64'(ic.tag_hit_way), 64'd1);
        check_value("w2_victim_t0", 64'(ic.tag_victim_way), 64'd1);
        ic.touch_en = 1'b1; ic.touch_way = 1'b1; tick();
        check_value("w2_victim_t1", 64'(ic.tag_victim_way), 64'd0);
        check_value("w2_nox", 64'($isunknown({ic.tag_hit, ic.tag_hit_way, ic.tag_victim_way, ic.tag_way_tags})), 64'd0);
        ic.lookup_valid = 1'b0; ic.touch_en = 1'b0;

        // NUM_WAYS = 8
        id.update_tag_en = 1'b1; id.update_tag_valid = 1'b1; id.update_tag_set = 1'b1;
        for (int w = 0; w < 8; w++) begin
            id.update_tag_way = 3'(w); id.update_tag_tag = 8'h10 + 8'(w);
            id.lookup_valid = (w == 3); id.lookup_set = 1'b1; id.lookup_tag = 8'hFF;
            tick();
            if (w == 3) check_value("w8_lowest_invalid", 64'(id.tag_victim_way), 64'd4);
        end
        id.update_tag_en = 1'b0;
        id.lookup_valid = 1'b1; id.lookup_tag = 8'h17; tick();
        check_value("w8_hit_way", 64'(id.tag_hit_way), 64'd7);
        check_value("w8_victim_init", 64'(id.tag_victim_way), 64'd0);
        id.lookup_valid = 1'b0;
        id.touch_en = 1'b1; id.touch_set = 1'b1; id.touch_way = 3'd0; tick(); id.touch_en = 1'b0;
        id.lookup_valid = 1'b1; id.lookup_tag = 8'hFF; tick();
        check_value("w8_victim_t0", 64'(id.tag_victim_way), 64'd4);
        id.touch_en = 1'b1; id.touch_way = 3'd4; tick();
        check_value("w8_victim_t4", 64'(id.tag_victim_way), 64'd2);
        check_value("w8_nox", 64'($isunknown({id.tag_hit, id.tag_hit_way, id.tag_victim_way, id.tag_way_tags})), 64'd0);
        id.lookup_valid = 1'b0; id.touch_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
